// File: rtl/dmem_stall_if.sv
// Multi-cycle data memory for the M stage: a small IDLE/WAIT FSM models LATENCY wait
// cycles, and MemBusyM asks the hazard unit to hold the pipeline until the access completes.
module dmem_stall_if #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemBusyM,
    output logic        MisalignM
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               req_s;
    logic [IDX_W-1:0]   live_idx_s;
    logic               done_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [1:0]         acc_off_s;
    logic               acc_wr_s;
    logic [31:0]        acc_wd_s;
    logic               mem_we_s;
    logic               unused_addr_s;

    assign req_s         = MemWriteM | MemtoRegM;
    assign live_idx_s    = ALUOutM[IDX_W+1:2];
    assign unused_addr_s = ^ALUOutM[31:IDX_W+2];

    // Next-state logic; the access being completed comes from the latches, or from the live inputs when LATENCY is 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        MemBusyM  = 1'b0;
        done_s    = 1'b0;
        acc_idx_s = idx_q;
        acc_off_s = off_q;
        acc_wr_s  = write_q;
        acc_wd_s  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    if (LATENCY == 0) begin
                        done_s    = 1'b1;
                        acc_idx_s = live_idx_s;
                        acc_off_s = ALUOutM[1:0];
                        acc_wr_s  = MemWriteM;
                        acc_wd_s  = WriteDataM;
                    end else begin
                        MemBusyM = 1'b1;
                        state_d  = S_WAIT;
                        cnt_d    = CNT_INIT;
                        idx_d    = live_idx_s;
                        off_d    = ALUOutM[1:0];
                        wdata_d  = WriteDataM;
                        write_d  = MemWriteM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!req_s) begin
                    // Request withdrawn (M flushed): drop the access without writing.
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    MemBusyM = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    done_s  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Completion-cycle outputs and write enable; misaligned stores are suppressed.
    always_comb begin
        ReadDataM = 32'd0;
        MisalignM = 1'b0;
        mem_we_s  = 1'b0;
        if (done_s) begin
            ReadDataM = mem_q[acc_idx_s];
            MisalignM = (acc_off_s != 2'd0);
            mem_we_s  = acc_wr_s & (acc_off_s == 2'd0) & ~reset;
        end else begin
            ReadDataM = 32'd0;
        end
    end

    // FSM state, wait counter and request latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'd0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Memory array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[acc_idx_s] <= acc_wd_s;
        end
    end

endmodule

// File: tb/tb_dmem_stall_if.sv
// Directed bench: a cycle-by-cycle vector table against a LATENCY=2 instance,
// plus a hand-written sequence against a LATENCY=0 instance.
module tb_dmem_stall_if;

    typedef struct {
        logic        rst;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        busy;
        logic [31:0] rd;
        logic        rdv;
        logic        mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst2, we2, re2;
    logic [31:0] addr2, wd2, rd2;
    logic        busy2, mis2;
    logic        rst0, we0, re0;
    logic [31:0] addr0, wd0, rd0;
    logic        busy0, mis0;

    int checks = 0;
    int failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    dmem_stall_if #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .clk(clk), .reset(rst2), .MemWriteM(we2), .MemtoRegM(re2),
        .ALUOutM(addr2), .WriteDataM(wd2),
        .ReadDataM(rd2), .MemBusyM(busy2), .MisalignM(mis2)
    );

    dmem_stall_if #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rst0), .MemWriteM(we0), .MemtoRegM(re0),
        .ALUOutM(addr0), .WriteDataM(wd0),
        .ReadDataM(rd0), .MemBusyM(busy0), .MisalignM(mis0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wd, input logic busy, input logic [31:0] rd,
                     input logic rdv, input logic mis);
        vec_t e;
        e.rst = rst; e.we = we; e.re = re; e.addr = addr; e.wd = wd;
        e.busy = busy; e.rd = rd; e.rdv = rdv; e.mis = mis;
        vq.push_back(e);
    endtask

    // One full LATENCY=2 access: two busy cycles, then the completion cycle.
    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input logic rdv,
                          input logic mis);
        v(1'b0, we, re, addr, wd, 1'b1, 32'd0, 1'b1, 1'b0);
        v(1'b0, we, re, addr, wd, 1'b1, 32'd0, 1'b1, 1'b0);
        v(1'b0, we, re, addr, wd, 1'b0, rd, rdv, mis);
    endtask

    initial begin
        // Reset, basic store/load
        v(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        access(1'b0, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        // Wrap-around: 0x104 aliases 0x04 with 64 words
        access(1'b1, 1'b0, 32'h04, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        access(1'b0, 1'b1, 32'h104, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
        // Misaligned store to word 8 is suppressed but still returns old data
        access(1'b1, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h21, 32'h12345678, 32'h11111111, 1'b1, 1'b1);
        access(1'b0, 1'b1, 32'h20, 32'h0, 32'h11111111, 1'b1, 1'b0);
        // Abort: request dropped in the first WAIT cycle
        v(1'b0, 1'b1, 1'b0, 32'h20, 32'h55555555, 1'b1, 32'h0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b0, 32'h20, 32'h55555555, 1'b0, 32'h0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        access(1'b0, 1'b1, 32'h20, 32'h0, 32'h11111111, 1'b1, 1'b0);
        // Reset pulsed in WAIT with the store still requested
        v(1'b0, 1'b1, 1'b0, 32'h20, 32'h77777777, 1'b1, 32'h0, 1'b1, 1'b0);
        v(1'b1, 1'b1, 1'b0, 32'h20, 32'h77777777, 1'b1, 32'h0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        access(1'b0, 1'b1, 32'h20, 32'h0, 32'h11111111, 1'b1, 1'b0);
        // Both control bits high acts as a store returning the pre-write value
        access(1'b1, 1'b1, 32'h20, 32'h99999999, 32'h11111111, 1'b1, 1'b0);
        access(1'b0, 1'b1, 32'h20, 32'h0, 32'h99999999, 1'b1, 1'b0);
        // Misaligned load returns the aligned word
        access(1'b0, 1'b1, 32'h22, 32'h0, 32'h99999999, 1'b1, 1'b1);
        v(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        rst2 = 1'b1; we2 = 1'b0; re2 = 1'b0; addr2 = 32'h0; wd2 = 32'h0;
        rst0 = 1'b1; we0 = 1'b0; re0 = 1'b0; addr0 = 32'h0; wd0 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;

        foreach (vq[i]) begin
            rst2 = vq[i].rst; we2 = vq[i].we; re2 = vq[i].re;
            addr2 = vq[i].addr; wd2 = vq[i].wd;
            @(negedge clk);
            chk($sformatf("row%0d_busy", i), {31'd0, busy2}, {31'd0, vq[i].busy});
            chk($sformatf("row%0d_mis", i), {31'd0, mis2}, {31'd0, vq[i].mis});
            if (vq[i].rdv) chk($sformatf("row%0d_rd", i), rd2, vq[i].rd);
            @(posedge clk);
            #1;
        end
        rst2 = 1'b0; we2 = 1'b0; re2 = 1'b0;

        // LATENCY=0: store then load on consecutive cycles
        we0 = 1'b1; re0 = 1'b0; addr0 = 32'h0; wd0 = 32'hA5A5A5A5;
        @(negedge clk);
        chk("l0_st_busy", {31'd0, busy0}, 32'd0);
        chk("l0_st_mis", {31'd0, mis0}, 32'd0);
        @(posedge clk); #1;
        we0 = 1'b0; re0 = 1'b1; addr0 = 32'h0; wd0 = 32'h0;
        @(negedge clk);
        chk("l0_ld_busy", {31'd0, busy0}, 32'd0);
        chk("l0_ld_rd", rd0, 32'hA5A5A5A5);
        @(posedge clk); #1;
        // Misaligned store must not overwrite word 0
        we0 = 1'b1; re0 = 1'b0; addr0 = 32'h1; wd0 = 32'h0;
        @(negedge clk);
        chk("l0_mst_busy", {31'd0, busy0}, 32'd0);
        chk("l0_mst_mis", {31'd0, mis0}, 32'd1);
        chk("l0_mst_rd", rd0, 32'hA5A5A5A5);
        @(posedge clk); #1;
        // 0x40 wraps to word 0 with 16 words
        we0 = 1'b0; re0 = 1'b1; addr0 = 32'h40;
        @(negedge clk);
        chk("l0_wrap_rd", rd0, 32'hA5A5A5A5);
        chk("l0_wrap_mis", {31'd0, mis0}, 32'd0);
        @(posedge clk); #1;
        re0 = 1'b0;
        @(negedge clk);
        chk("l0_idle_rd", rd0, 32'd0);
        chk("l0_idle_busy", {31'd0, busy0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
